// File: rtl/csr_trap_ctrl_pkg.sv
// rtl/csr_trap_ctrl_pkg.sv - shared encodings and constants for the CSR/trap sequencer
package csr_trap_ctrl_pkg;

    // Command class presented to the CSR file while a request is issued.
    typedef enum logic [1:0] {
        CS_IDLE = 2'b00,
        CS_RW   = 2'b01,
        CS_TRAP = 2'b10,
        CS_MRET = 2'b11
    } csr_state_e;

    // Operation field coming from decode.
    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_RW    = 2'b01,
        OP_ECALL = 2'b10,
        OP_MRET  = 2'b11
    } id_op_e;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_REDIR = 2'b10
    } ctrl_state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [63:0] PKG_ECALL_CAUSE = 64'hb;
    localparam logic [63:0] PKG_IRQ_CAUSE   = 64'h8000_0000_0000_0007;

    // Both synchronous traps and interrupts present as trap entry to the CSR file.
    function automatic csr_state_e op_to_csr_state(input id_op_e op);
        case (op)
            OP_RW:    op_to_csr_state = CS_RW;
            OP_ECALL: op_to_csr_state = CS_TRAP;
            OP_MRET:  op_to_csr_state = CS_MRET;
            default:  op_to_csr_state = CS_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/csr_trap_ctrl.sv
// rtl/csr_trap_ctrl.sv - sequences ID CSR/ECALL/MRET requests and timer interrupts into the CSR file
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_valid_i/id_ready_o           request handshake from decode
//   id_op_i, id_pc_i, id_csr_addr_i, id_wen_i, id_ren_i, id_wdata_i   request fields
//   irq_i, irq_pc_i                 machine timer pending level and PC to save
//   mstatus_mie_i, mie_mtie_i       interrupt enables from the CSR file
//   csr_state_o .. csr_cause_o      one-cycle command to the CSR file
//   csr_r_data_i, csr_dnpc_i        CSR read data and trap vector / mepc
//   done_o, rd_data_o               retire pulse and CSR read result
//   redirect_valid_o, redirect_pc_o PC redirect pulse and target
module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(PKG_ECALL_CAUSE),
    parameter logic [XLEN-1:0] IRQ_CAUSE   = XLEN'(PKG_IRQ_CAUSE)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid_i,
    output logic            id_ready_o,
    input  logic [1:0]      id_op_i,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [11:0]     id_csr_addr_i,
    input  logic            id_wen_i,
    input  logic            id_ren_i,
    input  logic [XLEN-1:0] id_wdata_i,
    input  logic            irq_i,
    input  logic [XLEN-1:0] irq_pc_i,
    input  logic            mstatus_mie_i,
    input  logic            mie_mtie_i,
    output logic [1:0]      csr_state_o,
    output logic [11:0]     csr_w_addr_o,
    output logic [11:0]     csr_r_addr_o,
    output logic            csr_wen_o,
    output logic            csr_ren_o,
    output logic [XLEN-1:0] csr_w_data_o,
    output logic [XLEN-1:0] csr_pc_o,
    output logic [XLEN-1:0] csr_cause_o,
    input  logic [XLEN-1:0] csr_r_data_i,
    input  logic [XLEN-1:0] csr_dnpc_i,
    output logic            done_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    ctrl_state_e     r_state;
    logic            r_is_irq;
    logic [1:0]      r_csr_state;
    logic [11:0]     r_csr_w_addr;
    logic [11:0]     r_csr_r_addr;
    logic            r_csr_wen;
    logic            r_csr_ren;
    logic [XLEN-1:0] r_csr_w_data;
    logic [XLEN-1:0] r_csr_pc;
    logic [XLEN-1:0] r_csr_cause;
    logic            r_done;
    logic [XLEN-1:0] r_rd_data;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;

    logic            w_idle;
    logic            w_irq_take;
    logic            w_is_rw;

    assign w_idle     = (r_state == ST_IDLE);
    // Interrupts are only sampled in IDLE, so a trap can never nest inside another.
    assign w_irq_take = irq_i & mstatus_mie_i & mie_mtie_i & w_idle;
    assign w_is_rw    = (id_op_i == OP_RW);
    // rst_n gating keeps ready low while the block is held in reset.
    assign id_ready_o = rst_n & w_idle & ~w_irq_take;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_is_irq         <= 1'b0;
            r_csr_state      <= CS_IDLE;
            r_csr_w_addr     <= '0;
            r_csr_r_addr     <= '0;
            r_csr_wen        <= 1'b0;
            r_csr_ren        <= 1'b0;
            r_csr_w_data     <= '0;
            r_csr_pc         <= '0;
            r_csr_cause      <= '0;
            r_done           <= 1'b0;
            r_rd_data        <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_done           <= 1'b0;
            r_redirect_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_irq_take) begin
                        r_state     <= ST_ISSUE;
                        r_is_irq    <= 1'b1;
                        r_csr_state <= CS_TRAP;
                        r_csr_pc    <= irq_pc_i;
                        r_csr_cause <= IRQ_CAUSE;
                        r_csr_wen   <= 1'b0;
                        r_csr_ren   <= 1'b0;
                    end else if (id_valid_i) begin
                        if (id_op_i == OP_NONE) begin
                            // Empty op is retired without touching the CSR file.
                            r_done <= 1'b1;
                        end else begin
                            r_state      <= ST_ISSUE;
                            r_is_irq     <= 1'b0;
                            r_csr_state  <= op_to_csr_state(id_op_e'(id_op_i));
                            r_csr_w_addr <= id_csr_addr_i;
                            r_csr_r_addr <= id_csr_addr_i;
                            r_csr_w_data <= id_wdata_i;
                            r_csr_pc     <= id_pc_i;
                            r_csr_wen    <= w_is_rw & id_wen_i;
                            r_csr_ren    <= w_is_rw & id_ren_i;
                            if (id_op_i == OP_ECALL) begin
                                r_csr_cause <= ECALL_CAUSE;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    r_csr_state <= CS_IDLE;
                    r_csr_wen   <= 1'b0;
                    r_csr_ren   <= 1'b0;
                    if (r_csr_state == CS_RW) begin
                        r_rd_data <= r_csr_ren ? csr_r_data_i : '0;
                        r_done    <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_redirect_pc    <= csr_dnpc_i;
                        r_redirect_valid <= 1'b1;
                        // An interrupt did not come from ID, so nothing retires.
                        r_done           <= ~r_is_irq;
                        r_state          <= ST_REDIR;
                    end
                end
                ST_REDIR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign csr_state_o      = r_csr_state;
    assign csr_w_addr_o     = r_csr_w_addr;
    assign csr_r_addr_o     = r_csr_r_addr;
    assign csr_wen_o        = r_csr_wen;
    assign csr_ren_o        = r_csr_ren;
    assign csr_w_data_o     = r_csr_w_data;
    assign csr_pc_o         = r_csr_pc;
    assign csr_cause_o      = r_csr_cause;
    assign done_o           = r_done;
    assign rd_data_o        = r_rd_data;
    assign redirect_valid_o = r_redirect_valid;
    assign redirect_pc_o    = r_redirect_pc;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb/tb_csr_trap_ctrl.sv - self-checking bench for csr_trap_ctrl
module tb_csr_trap_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid_i;
    logic        id_ready_o;
    logic [1:0]  id_op_i;
    logic [63:0] id_pc_i;
    logic [11:0] id_csr_addr_i;
    logic        id_wen_i;
    logic        id_ren_i;
    logic [63:0] id_wdata_i;
    logic        irq_i;
    logic [63:0] irq_pc_i;
    logic        mstatus_mie_i;
    logic        mie_mtie_i;
    logic [1:0]  csr_state_o;
    logic [11:0] csr_w_addr_o;
    logic [11:0] csr_r_addr_o;
    logic        csr_wen_o;
    logic        csr_ren_o;
    logic [63:0] csr_w_data_o;
    logic [63:0] csr_pc_o;
    logic [63:0] csr_cause_o;
    logic [63:0] csr_r_data_i;
    logic [63:0] csr_dnpc_i;
    logic        done_o;
    logic [63:0] rd_data_o;
    logic        redirect_valid_o;
    logic [63:0] redirect_pc_o;

    int checks   = 0;
    int failures = 0;

    csr_trap_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_op_i(id_op_i),
        .id_pc_i(id_pc_i), .id_csr_addr_i(id_csr_addr_i), .id_wen_i(id_wen_i),
        .id_ren_i(id_ren_i), .id_wdata_i(id_wdata_i),
        .irq_i(irq_i), .irq_pc_i(irq_pc_i),
        .mstatus_mie_i(mstatus_mie_i), .mie_mtie_i(mie_mtie_i),
        .csr_state_o(csr_state_o), .csr_w_addr_o(csr_w_addr_o), .csr_r_addr_o(csr_r_addr_o),
        .csr_wen_o(csr_wen_o), .csr_ren_o(csr_ren_o), .csr_w_data_o(csr_w_data_o),
        .csr_pc_o(csr_pc_o), .csr_cause_o(csr_cause_o),
        .csr_r_data_i(csr_r_data_i), .csr_dnpc_i(csr_dnpc_i),
        .done_o(done_o), .rd_data_o(rd_data_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal CSR file: mscratch, mtvec, mepc.
    logic [63:0] m_mscratch = '0;
    logic [63:0] m_mtvec    = '0;
    logic [63:0] m_mepc     = '0;

    always @(posedge clk) begin
        if (csr_wen_o) begin
            case (csr_w_addr_o)
                12'h340: m_mscratch <= csr_w_data_o;
                12'h305: m_mtvec    <= csr_w_data_o;
                12'h341: m_mepc     <= csr_w_data_o;
                default: ;
            endcase
        end
    end

    always_comb begin
        csr_r_data_i = '0;
        case (csr_r_addr_o)
            12'h340: csr_r_data_i = m_mscratch;
            12'h305: csr_r_data_i = m_mtvec;
            12'h341: csr_r_data_i = m_mepc;
            default: csr_r_data_i = '0;
        endcase
        csr_dnpc_i = (csr_state_o == 2'b11) ? m_mepc : m_mtvec;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic        wen;
        logic        ren;
        logic [63:0] wdata;
        logic [63:0] pc;
        logic [1:0]  e_state;
        logic        e_wen;
        logic        e_ren;
        logic        e_redir;
        logic [63:0] e_val;   // rd_data for RW, redirect target for traps
    } vec_t;

    vec_t vecs[9];

    // Waits for ready, hands over one request and checks both output phases.
    task automatic do_req(input vec_t v, input string tag);
        int cnt;
        @(negedge clk);
        id_op_i = v.op; id_csr_addr_i = v.addr; id_wen_i = v.wen; id_ren_i = v.ren;
        id_wdata_i = v.wdata; id_pc_i = v.pc; id_valid_i = 1'b1;
        cnt = 0;
        while (!id_ready_o && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, "_ready"}, {63'd0, id_ready_o}, 64'd1);
        @(negedge clk);
        id_valid_i = 1'b0;
        chk({tag, "_state"}, {62'd0, csr_state_o}, {62'd0, v.e_state});
        chk({tag, "_wen"}, {63'd0, csr_wen_o}, {63'd0, v.e_wen});
        chk({tag, "_ren"}, {63'd0, csr_ren_o}, {63'd0, v.e_ren});
        if (v.op == 2'b00) begin
            chk({tag, "_done"}, {63'd0, done_o}, 64'd1);
        end else begin
            chk({tag, "_pc"}, csr_pc_o, v.pc);
            if (v.op == 2'b10) chk({tag, "_cause"}, csr_cause_o, 64'hb);
            if (v.op == 2'b01) chk({tag, "_addr"}, {52'd0, csr_r_addr_o}, {52'd0, v.addr});
            @(negedge clk);
            chk({tag, "_done"}, {63'd0, done_o}, 64'd1);
            chk({tag, "_redir"}, {63'd0, redirect_valid_o}, {63'd0, v.e_redir});
            if (v.e_redir) chk({tag, "_rpc"}, redirect_pc_o, v.e_val);
            else           chk({tag, "_rd"}, rd_data_o, v.e_val);
            chk({tag, "_idle_state"}, {62'd0, csr_state_o}, 64'd0);
        end
    endtask

    initial begin
        int cnt;
        bit saw;
        vecs[0] = '{2'b01, 12'h305, 1'b1, 1'b0, 64'h8000_0100, 64'h8000_0000, 2'b01, 1'b1, 1'b0, 1'b0, 64'h0};
        vecs[1] = '{2'b01, 12'h305, 1'b0, 1'b1, 64'h0,         64'h8000_0004, 2'b01, 1'b0, 1'b1, 1'b0, 64'h8000_0100};
        vecs[2] = '{2'b01, 12'h341, 1'b1, 1'b1, 64'h8000_0044, 64'h8000_0008, 2'b01, 1'b1, 1'b1, 1'b0, 64'h0};
        vecs[3] = '{2'b10, 12'h305, 1'b1, 1'b1, 64'h0,         64'h8000_0040, 2'b10, 1'b0, 1'b0, 1'b1, 64'h8000_0100};
        vecs[4] = '{2'b11, 12'h000, 1'b0, 1'b0, 64'h0,         64'h8000_0104, 2'b11, 1'b0, 1'b0, 1'b1, 64'h8000_0044};
        vecs[5] = '{2'b01, 12'h340, 1'b1, 1'b1, 64'h1234,      64'h8000_0048, 2'b01, 1'b1, 1'b1, 1'b0, 64'h0};
        vecs[6] = '{2'b01, 12'h340, 1'b0, 1'b1, 64'h0,         64'h8000_004c, 2'b01, 1'b0, 1'b1, 1'b0, 64'h1234};
        vecs[7] = '{2'b00, 12'h305, 1'b1, 1'b1, 64'hdead,      64'h8000_0050, 2'b00, 1'b0, 1'b0, 1'b0, 64'h0};
        vecs[8] = '{2'b01, 12'h341, 1'b0, 1'b1, 64'h0,         64'h8000_0054, 2'b01, 1'b0, 1'b1, 1'b0, 64'h8000_0044};

        rst_n = 1'b0; id_valid_i = 1'b0; id_op_i = 2'b00; id_pc_i = '0; id_csr_addr_i = '0;
        id_wen_i = 1'b0; id_ren_i = 1'b0; id_wdata_i = '0; irq_i = 1'b0; irq_pc_i = '0;
        mstatus_mie_i = 1'b0; mie_mtie_i = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, id_ready_o}, 64'd0);
        chk("rst_done", {63'd0, done_o}, 64'd0);
        chk("rst_redir", {63'd0, redirect_valid_o}, 64'd0);
        chk("rst_state", {62'd0, csr_state_o}, 64'd0);
        chk("rst_rd", rd_data_o, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {63'd0, id_ready_o}, 64'd1);

        for (int i = 0; i < 9; i++) do_req(vecs[i], $sformatf("vec%0d", i));

        // Masked interrupts: MIE=0, then MTIE=0; requests flow normally.
        irq_i = 1'b1; irq_pc_i = 64'h8000_0200; mstatus_mie_i = 1'b0; mie_mtie_i = 1'b1;
        do_req(vecs[1], "mask_mie");
        mstatus_mie_i = 1'b1; mie_mtie_i = 1'b0;
        do_req(vecs[6], "mask_mtie");

        // Interrupt wins over a simultaneous RW request.
        @(negedge clk);
        mie_mtie_i = 1'b1;
        id_op_i = 2'b01; id_csr_addr_i = 12'h305; id_wen_i = 1'b0; id_ren_i = 1'b1;
        id_pc_i = 64'h8000_0060; id_valid_i = 1'b1;
        #1;
        chk("irq_ready_low", {63'd0, id_ready_o}, 64'd0);
        @(negedge clk);
        chk("irq_state", {62'd0, csr_state_o}, 64'd2);
        chk("irq_cause", csr_cause_o, 64'h8000_0000_0000_0007);
        chk("irq_pc", csr_pc_o, 64'h8000_0200);
        chk("irq_wen", {63'd0, csr_wen_o}, 64'd0);
        irq_i = 1'b0; mstatus_mie_i = 1'b0;   // CSR file clears MIE on trap entry
        @(negedge clk);
        chk("irq_redir", {63'd0, redirect_valid_o}, 64'd1);
        chk("irq_done", {63'd0, done_o}, 64'd0);
        chk("irq_rpc", redirect_pc_o, 64'h8000_0100);
        chk("irq_redir_ready", {63'd0, id_ready_o}, 64'd0);
        @(negedge clk);
        chk("irq_then_ready", {63'd0, id_ready_o}, 64'd1);
        @(negedge clk);
        id_valid_i = 1'b0;
        chk("held_state", {62'd0, csr_state_o}, 64'd1);
        chk("held_ren", {63'd0, csr_ren_o}, 64'd1);
        @(negedge clk);
        chk("held_done", {63'd0, done_o}, 64'd1);
        chk("held_rd", rd_data_o, 64'h8000_0100);

        // Reset while an ECALL is in ISSUE.
        @(negedge clk);
        id_op_i = 2'b10; id_pc_i = 64'h8000_0070; id_valid_i = 1'b1;
        cnt = 0;
        while (!id_ready_o && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("rsti_ready", {63'd0, id_ready_o}, 64'd1);
        @(negedge clk);
        id_valid_i = 1'b0;
        chk("rsti_issue", {62'd0, csr_state_o}, 64'd2);
        rst_n = 1'b0;
        #1;
        chk("rsti_state0", {62'd0, csr_state_o}, 64'd0);
        chk("rsti_pc0", csr_pc_o, 64'd0);
        chk("rsti_cause0", csr_cause_o, 64'd0);
        chk("rsti_ready0", {63'd0, id_ready_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (redirect_valid_o || done_o) saw = 1'b1;
        end
        chk("rsti_no_pulse", {63'd0, saw}, 64'd0);
        chk("rsti_ready1", {63'd0, id_ready_o}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
